// File: rtl/frame_loader.sv
// Assembles a byte stream into 24-bit display-memory words, three bytes per word,
// and writes one frame of WORDS words starting at address 0 after each start-of-frame.
module frame_loader #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 48,
  parameter int WORDS  = WIDTH * HEIGHT / 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sof,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_ready,
  output logic [11:0] addr_a,
  output logic [23:0] data_in_a,
  output logic        wr_en,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  localparam logic [11:0] LAST_ADDR = 12'(WORDS - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] word_q, word_d;
  logic [15:0] hi_q, hi_d;
  logic [11:0] addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      word_q  <= 12'd0;
      hi_q    <= 16'd0;
      addr_q  <= 12'd0;
      data_q  <= 24'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    // Start-of-frame clears the sticky flag; otherwise any byte offered while
    // not collecting is lost and remembered.
    ovr_d   = i_sof ? 1'b0 : (ovr_q | (i_byte_valid && state_q != COLLECT));

    if (i_sof) begin
      state_d = COLLECT;
      idx_d   = 2'd0;
      word_d  = 12'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (i_byte_valid) begin
            case (idx_q)
              2'd0:    begin hi_d[15:8] = i_byte; idx_d = 2'd1; end
              2'd1:    begin hi_d[7:0]  = i_byte; idx_d = 2'd2; end
              default: begin
                addr_d  = word_q;
                data_d  = {hi_q, i_byte};
                idx_d   = 2'd0;
                state_d = WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (word_q == LAST_ADDR) begin
            state_d = IDLE;
            word_d  = 12'd0;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
            word_d  = word_q + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == COLLECT);
    o_busy  = (state_q != IDLE);
    wr_en   = (state_q == WRITE);
  end

  assign addr_a       = addr_q;
  assign data_in_a    = data_q;
  assign o_frame_done = done_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: per-cycle vector table for control outputs, plus a
// write scoreboard that checks address, data and one-cycle latency of every wr_en.
module tb_frame_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_sof = 1'b0;
  logic [7:0]  i_byte = 8'd0;
  logic        i_byte_valid = 1'b0;
  logic        o_ready;
  logic [11:0] addr_a;
  logic [23:0] data_in_a;
  logic        wr_en;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overrun;

  frame_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sof        (i_sof),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_ready      (o_ready),
    .addr_a       (addr_a),
    .data_in_a    (data_in_a),
    .wr_en        (wr_en),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  localparam int WORDS = 2304;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cnt = 0;

  typedef struct {
    logic [11:0] addr;
    logic [23:0] data;
    int          at;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic sof, vld;
    logic [7:0] b;
    logic push;
    logic [11:0] a;
    logic [23:0] d;
    logic ready, busy, wr, done, ovr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard side: every write must match the oldest expectation, on time.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_frame_done) done_cnt++;
      if (wr_en) begin
        if (sb.size() == 0) begin
          check("unexpected_wr_en", 32'(wr_en), 32'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 32'(addr_a), 32'(e.addr));
          check("wr_data", 32'(data_in_a), 32'(e.data));
          check("wr_latency", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [23:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.at   = cyc + 1;
    sb.push_back(e);
  endtask

  // Called at a negedge; waits for o_ready, presents one byte, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b, input logic push,
                           input logic [11:0] a, input logic [23:0] d);
    int w = 0;
    while (!o_ready && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    i_byte = b;
    i_byte_valid = 1'b1;
    if (push) push_wr(a, d);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] a, input logic [23:0] d, input int gap);
    send_byte(d[23:16], 1'b0, a, d);
    repeat (gap) @(negedge i_clk);
    send_byte(d[15:8], 1'b0, a, d);
    repeat (gap) @(negedge i_clk);
    send_byte(d[7:0], 1'b1, a, d);
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic pulse_sof();
    i_sof = 1'b1;
    @(negedge i_clk);
    i_sof = 1'b0;
  endtask

  function automatic logic [23:0] pat(input int w);
    logic [11:0] x;
    x = 12'(w);
    return {x[7:0], x[11:4] ^ 8'h5A, ~x[7:0]};
  endfunction

  function automatic vec_t mk(input logic sof, input logic vld, input logic [7:0] b,
                              input logic push, input logic [11:0] a, input logic [23:0] d,
                              input logic ready, input logic busy, input logic wr,
                              input logic done, input logic ovr);
    vec_t v;
    v.sof = sof; v.vld = vld; v.b = b; v.push = push; v.a = a; v.d = d;
    v.ready = ready; v.busy = busy; v.wr = wr; v.done = done; v.ovr = ovr;
    return v;
  endfunction

  task automatic full_frame(input int gap, input string tag);
    int base;
    base = done_cnt;
    pulse_sof();
    for (int w = 0; w < WORDS; w++) send_word(12'(w), pat(w), gap);
    repeat (4) @(negedge i_clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    check({tag, "_addr_hold"}, 32'(addr_a), 32'd2303);
    check({tag, "_data_hold"}, 32'(data_in_a), 32'(pat(WORDS - 1)));
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[18];

  initial begin
    int base;

    // Single word, then a byte offered during WRITE, then an sof that carries a byte.
    tbl[0]  = mk(1, 0, 8'h00, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'hAB, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 8'hCD, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'hEF, 1, 12'd0, 24'hABCDEF, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 8'h01, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 8'h02, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 8'h03, 1, 12'd1, 24'h010203, 0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 1, 8'hFF, 0, 12'd0, 24'h0,      1, 1, 0, 0, 1);
    tbl[9]  = mk(0, 1, 8'h04, 0, 12'd0, 24'h0,      1, 1, 0, 0, 1);
    tbl[10] = mk(0, 1, 8'h05, 0, 12'd0, 24'h0,      1, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 8'h06, 1, 12'd2, 24'h040506, 0, 1, 1, 0, 1);
    tbl[12] = mk(0, 0, 8'h00, 0, 12'd0, 24'h0,      1, 1, 0, 0, 1);
    tbl[13] = mk(1, 1, 8'h77, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 8'h11, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 8'h22, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 8'h33, 1, 12'd0, 24'h112233, 0, 1, 1, 0, 0);
    tbl[17] = mk(0, 0, 8'h00, 0, 12'd0, 24'h0,      1, 1, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_data", 32'(data_in_a), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 18; i++) begin
      i_sof = tbl[i].sof;
      i_byte_valid = tbl[i].vld;
      i_byte = tbl[i].b;
      if (tbl[i].push) push_wr(tbl[i].a, tbl[i].d);
      @(negedge i_clk);
      check($sformatf("v%0d_ready", i), 32'(o_ready), 32'(tbl[i].ready));
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wr));
      check($sformatf("v%0d_done", i), 32'(o_frame_done), 32'(tbl[i].done));
      check($sformatf("v%0d_overrun", i), 32'(o_overrun), 32'(tbl[i].ovr));
    end
    i_sof = 1'b0;
    i_byte_valid = 1'b0;

    // Abort after five bytes: restart at address 0, no frame_done.
    base = done_cnt;
    pulse_sof();
    send_word(12'd0, 24'hAABBCC, 0);
    send_byte(8'hDD, 1'b0, 12'd0, 24'h0);
    send_byte(8'hEE, 1'b0, 12'd0, 24'h0);
    pulse_sof();
    send_word(12'd0, 24'h112233, 0);
    repeat (3) @(negedge i_clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_sb_drained", 32'(sb.size()), 32'd0);
    check("abort_addr_next", 32'(o_busy), 32'd1);

    full_frame(0, "frame");
    full_frame(2, "sparse");

    // Bytes after a completed frame are dropped and flagged.
    i_byte = 8'h99;
    i_byte_valid = 1'b1;
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    check("idle_byte_overrun", 32'(o_overrun), 32'd1);

    // Async reset mid-frame with the sticky flag and write registers populated.
    pulse_sof();
    send_word(12'd0, 24'h123456, 0);
    i_byte = 8'h5C;
    i_byte_valid = 1'b1;
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    check("wr_cycle_overrun", 32'(o_overrun), 32'd1);
    send_byte(8'h42, 1'b0, 12'd0, 24'h0);
    #2 i_rst = 1'b1;
    #1;
    check("arst_ready", 32'(o_ready), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_done", 32'(o_frame_done), 32'd0);
    check("arst_overrun", 32'(o_overrun), 32'd0);
    check("arst_addr", 32'(addr_a), 32'd0);
    check("arst_data", 32'(data_in_a), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_byte = 8'(8'hE0 + i);
      i_byte_valid = 1'b1;
      @(negedge i_clk);
    end
    i_byte_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("post_rst_overrun", 32'(o_overrun), 32'd1);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_data", 32'(data_in_a), 32'd0);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got t=%0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
